mc_fifo: RTL and testbench
==========================

Name: mc_fifo

Overview:
- Parametrised multicast controller with an output buffer, for the GIN X-bus/Y-bus.
- Compares each bus transaction's tag with a locally configured ID.
- Matching and broadcast transactions are captured into a small FIFO and drained to the PE side with a valid/ready handshake.
- Non-matching transactions are acknowledged and dropped, so this controller never stalls the bus for traffic addressed elsewhere.

Parameters:
- DATA_BITWIDTH, 16, payload width.
- TAG_BITWIDTH, 4, width of ID and tag; the all-ones tag is reserved as broadcast.
- FIFO_DEPTH, 2, buffer entries; power of two, minimum 2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_cfg_en  in  1  config strobe from the scan-chain controller.
- i_cfg_id  in  TAG_BITWIDTH  ID value loaded when i_cfg_en=1.
- i_tag  in  TAG_BITWIDTH  destination tag of the current bus transaction.
- i_data  in  DATA_BITWIDTH  bus payload.
- i_valid  in  1  bus transaction valid.
- o_ready  out  1  ready back to the bus.
- o_valid  out  1  PE-side valid.
- o_data  out  DATA_BITWIDTH  PE-side payload.
- i_ready  in  1  PE-side ready.
- o_pkt_cnt  out  16  count of accepted matching packets (see Optional Feature).

Behaviour:
- Clock i_clk; reset i_rst, synchronous, active-high.
- Reset values:
  - id_reg=0, FIFO empty (wr_ptr=rd_ptr=0, count=0).
  - o_valid=0, o_data=0, o_pkt_cnt=0.
  - o_ready=1 after reset; it is combinational, see below.
- ID register:
  - On a clock edge with i_cfg_en=1, id_reg<=i_cfg_id.
  - The new ID takes effect from the next cycle.
- Match:
  - match = (i_tag==id_reg) || (i_tag=={TAG_BITWIDTH{1'b1}}).
  - Evaluated combinationally against the current id_reg.
- o_ready (combinational) = !i_cfg_en && (!match || !full).
  - During config the bus is held off.
  - A non-matching tag is always ready.
- Accept: i_valid && o_ready.
  - push = accept && match: i_data is written at wr_ptr, wr_ptr increments and wraps mod FIFO_DEPTH.
  - accept && !match: the transaction is consumed, nothing is stored, no state change.
- Pop: o_valid && i_ready; rd_ptr increments and wraps.
- Output (first-word-fall-through):
  - o_valid = (count!=0).
  - o_data = entry at rd_ptr when o_valid, else 0.
  - Latency from push to o_valid is 1 cycle; no combinational path from i_data to o_data.
- count update: push&&!pop -> +1; pop&&!push -> -1; both or neither -> unchanged.
- Boundary conditions:
  - Full (count==FIFO_DEPTH): o_ready=0 for matching tags, even if a pop occurs in the same cycle. There is no ready passthrough, by design, to break the timing path.
  - Empty: simultaneous push+pop cannot occur because pop requires o_valid.
  - Push while count==FIFO_DEPTH-1 with no pop: full in the next cycle.
  - i_cfg_en asserted mid-stream: no new accepts; buffered entries keep draining with their original match.
  - Reset mid-operation: buffered data is discarded, pointers cleared, no output beat in the reset cycle or the following one.
  - Broadcast tag: always matches, including when id_reg equals all-ones.

Optional Feature:
- Macro MC_FIFO_STATS_EN.
- Defined: o_pkt_cnt increments by 1 on every push, saturates at 16'hFFFF, and clears on reset and on any cycle with i_cfg_en=1.
- Undefined: o_pkt_cnt tied to 0 and no counter logic is synthesised; all other behaviour is identical.

Test Plan:
- Reset, then i_cfg_en=1, i_cfg_id=4'h5 for 1 cycle; send i_tag=5, i_data=16'hA1A1, i_valid=1, i_ready=1 -> o_valid=1 and o_data=16'hA1A1 one cycle later; o_ready stays 1.
- id=5; send i_tag=3, i_data=16'h1234 -> o_ready=1, transaction consumed, o_valid remains 0, count unchanged.
- id=5, i_ready=0; send three tag-5 beats 16'h0001, 16'h0002, 16'h0003 -> first two accepted, o_ready=0 on the third (FIFO_DEPTH=2). Raise i_ready -> outputs 0001, then 0002; the third is accepted once not full.
- id=5; send i_tag=4'hF, i_data=16'hBEEF -> accepted and output as broadcast. Then i_cfg_en=1 with i_valid=1 -> o_ready=0 while i_cfg_en is high.
- Fill FIFO with 2 entries, assert i_rst for 1 cycle -> o_valid=0, o_data=0, o_ready=1, o_pkt_cnt=0; no stale data appears afterwards.
- With MC_FIFO_STATS_EN: 10 matching pushes -> o_pkt_cnt=10. Pulse i_cfg_en -> 0. Preload near saturation via a long stream -> holds at 16'hFFFF.

Source files
------------

// File: rtl/mc_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mc_fifo                                                          |
// | Brief   : GIN multicast controller: tag/ID match into a small FWFT FIFO,   |
// |           non-matching traffic is acked and dropped. Optional packet       |
// |           counter enabled by macro MC_FIFO_STATS_EN.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mc_fifo #(
    parameter int DATA_BITWIDTH = 16,
    parameter int TAG_BITWIDTH  = 4,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_cfg_en,
    input  logic [TAG_BITWIDTH-1:0]  i_cfg_id,
    input  logic [TAG_BITWIDTH-1:0]  i_tag,
    input  logic [DATA_BITWIDTH-1:0] i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [DATA_BITWIDTH-1:0] o_data,
    input  logic                     i_ready,
    output logic [15:0]              o_pkt_cnt
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [TAG_BITWIDTH-1:0] c_bcast = {TAG_BITWIDTH{1'b1}};

    logic [TAG_BITWIDTH-1:0]  r_id;
    logic [DATA_BITWIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]       r_wr_ptr;
    logic [c_ptr_w-1:0]       r_rd_ptr;
    logic [c_cnt_w-1:0]       r_count;

    logic w_match;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_match = (i_tag == r_id) || (i_tag == c_bcast);
    assign w_full  = (r_count == c_full);
    // Full blocks matching traffic even if a pop happens this cycle: no ready passthrough.
    assign o_ready = !i_cfg_en && (!w_match || !w_full);
    assign w_push  = i_valid && o_ready && w_match;

    // Gating with i_rst suppresses any output beat during the reset cycle itself.
    assign o_valid = !i_rst && (r_count != '0);
    assign w_pop   = o_valid && i_ready;
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_id <= '0;
        end else if (i_cfg_en) begin
            r_id <= i_cfg_id;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

`ifdef MC_FIFO_STATS_EN
    logic [15:0] r_pkt_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_cfg_en) begin
            r_pkt_cnt <= '0;
        end else if (w_push && (r_pkt_cnt != 16'hFFFF)) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    assign o_pkt_cnt = r_pkt_cnt;
`else
    assign o_pkt_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mc_fifo                                                       |
// | Brief   : Self-checking bench for mc_fifo against a queue-based model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mc_fifo;

    localparam int DW    = 16;
    localparam int TW    = 4;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_en;
    logic [TW-1:0] cfg_id;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready_out;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          ready_in;
    logic [15:0]   pkt_cnt;

    int errors = 0;
    int checks = 0;

    // Reference state: what the block should hold, expressed at transaction level.
    logic [DW-1:0] m_q [$];
    logic [TW-1:0] m_id  = '0;
    int            m_cnt = 0;

    always #5 clk = ~clk;

    mc_fifo #(
        .DATA_BITWIDTH(DW),
        .TAG_BITWIDTH (TW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_cfg_en (cfg_en),
        .i_cfg_id (cfg_id),
        .i_tag    (tag),
        .i_data   (data),
        .i_valid  (valid),
        .o_ready  (ready_out),
        .o_valid  (valid_out),
        .o_data   (data_out),
        .i_ready  (ready_in),
        .o_pkt_cnt(pkt_cnt)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", name, obs, exp, $time);
        end
    endtask

    // One bus cycle: drive, check outputs mid-cycle, then advance the model at the edge.
    task automatic tick(input logic r, input logic ce, input logic [TW-1:0] cid,
                        input logic [TW-1:0] t, input logic [DW-1:0] d,
                        input logic v, input logic rdy);
        logic          e_match, e_ready, e_valid, e_push, e_pop;
        logic [DW-1:0] e_data;
        rst = r; cfg_en = ce; cfg_id = cid; tag = t; data = d; valid = v; ready_in = rdy;
        @(negedge clk);
        e_match = (t == m_id) || (t == {TW{1'b1}});
        e_ready = !ce && (!e_match || (m_q.size() < DEPTH));
        e_valid = !r && (m_q.size() != 0);
        e_data  = e_valid ? m_q[0] : '0;
        chk("o_ready",   32'(ready_out), 32'(e_ready));
        chk("o_valid",   32'(valid_out), 32'(e_valid));
        chk("o_data",    32'(data_out),  32'(e_data));
        chk("o_pkt_cnt", 32'(pkt_cnt),   32'(m_cnt));
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_id  = '0;
            m_cnt = 0;
        end else begin
            e_push = v && e_ready && e_match;
            e_pop  = e_valid && rdy;
            if (e_pop) void'(m_q.pop_front());
            if (e_push) begin
                m_q.push_back(d);
`ifdef MC_FIFO_STATS_EN
                if (m_cnt < 65535) m_cnt++;
`endif
            end
            if (ce) begin
                m_id  = cid;
                m_cnt = 0;
            end
        end
        #1;
    endtask

    initial begin
        logic [TW-1:0] rid;
        logic [TW-1:0] rtag;
        rst = 1'b1; cfg_en = 1'b0; cfg_id = '0; tag = '0; data = '0; valid = 1'b0; ready_in = 1'b0;

        // Reset, then configure ID 5 and send one matching beat.
        tick(1, 0, 4'h0, 4'h0, 16'h0000, 0, 1);
        tick(0, 0, 4'h0, 4'h0, 16'h0000, 0, 1);
        tick(0, 1, 4'h5, 4'h0, 16'h0000, 0, 1);
        tick(0, 0, 4'h0, 4'h5, 16'hA1A1, 1, 1);
        tick(0, 0, 4'h0, 4'h0, 16'h0000, 0, 1);
        chk("id_drain_empty", 32'(m_q.size()), 32'(0));

        // Non-matching tag is consumed and dropped.
        tick(0, 0, 4'h0, 4'h3, 16'h1234, 1, 1);
        tick(0, 0, 4'h0, 4'h0, 16'h0000, 0, 1);

        // Backpressure: third beat held off while full, then drains in order.
        tick(0, 0, 4'h0, 4'h5, 16'h0001, 1, 0);
        tick(0, 0, 4'h0, 4'h5, 16'h0002, 1, 0);
        tick(0, 0, 4'h0, 4'h5, 16'h0003, 1, 0);
        tick(0, 0, 4'h0, 4'h5, 16'h0003, 1, 1);
        tick(0, 0, 4'h0, 4'h5, 16'h0003, 1, 1);
        tick(0, 0, 4'h0, 4'h0, 16'h0000, 0, 1);
        tick(0, 0, 4'h0, 4'h0, 16'h0000, 0, 1);

        // Broadcast, then config while valid holds the bus off.
        tick(0, 0, 4'h0, 4'hF, 16'hBEEF, 1, 1);
        tick(0, 1, 4'h7, 4'h5, 16'h5555, 1, 1);
        tick(0, 0, 4'h0, 4'h7, 16'h7777, 1, 1);
        tick(0, 0, 4'h0, 4'h0, 16'h0000, 0, 1);

        // Broadcast with id all-ones.
        tick(0, 1, 4'hF, 4'h0, 16'h0000, 0, 1);
        tick(0, 0, 4'h0, 4'hF, 16'hF00F, 1, 0);

        // Fill and reset mid-operation.
        tick(0, 0, 4'h0, 4'hF, 16'hCAFE, 1, 0);
        tick(1, 0, 4'h0, 4'hF, 16'hDEAD, 1, 1);
        tick(0, 0, 4'h0, 4'h0, 16'h0000, 0, 1);
        tick(0, 0, 4'h0, 4'h0, 16'h0000, 0, 1);

        // Counter: ten matching pushes, then a config pulse clears it.
        tick(0, 1, 4'h5, 4'h0, 16'h0000, 0, 1);
        for (int i = 0; i < 10; i++) tick(0, 0, 4'h0, 4'h5, 16'(i + 16'h100), 1, 1);
        tick(0, 0, 4'h0, 4'h0, 16'h0000, 0, 1);
        tick(0, 1, 4'h5, 4'h0, 16'h0000, 0, 1);
        tick(0, 0, 4'h0, 4'h0, 16'h0000, 0, 1);

`ifdef MC_FIFO_STATS_EN
        // Long stream to reach counter saturation.
        for (int i = 0; i < 65540; i++) tick(0, 0, 4'h0, 4'h5, 16'(i), 1, 1);
        chk("pkt_cnt_sat", 32'(pkt_cnt), 32'hFFFF);
`endif

        // Randomized traffic.
        rid = 4'h5;
        for (int i = 0; i < 600; i++) begin
            logic r, ce, v, rdy;
            logic [TW-1:0] cid;
            r   = ($urandom % 64) == 0;
            ce  = ($urandom % 16) == 0;
            cid = ($urandom % 2) ? 4'h5 : 4'(($urandom % 16));
            if (ce) rid = cid;
            case ($urandom % 4)
                0, 1:    rtag = rid;
                2:       rtag = 4'hF;
                default: rtag = 4'($urandom % 16);
            endcase
            v   = ($urandom % 4) != 0;
            rdy = ($urandom % 2) != 0;
            tick(r, ce, cid, rtag, 16'($urandom), v, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
